// File: rtl/exor_gate.sv
// exor_gate: bitwise XOR with a zero-latency combinational result and a
// registered, valid-qualified copy plus a parity flag.
// Optional feature macro: EXOR_GATE_DIFF_COUNT_EN adds a saturating
// differing-bit counter on diff_cnt. Without it, diff_cnt is tied to 0.
module exor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid,
    output logic             parity,
    output logic [CNT_W-1:0] diff_cnt
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] c_d;
    logic             parity_d;
    logic             parity_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Combinational difference; independent of clk and rst_n.
    assign x = a ^ b;
    assign c = x;

    // Next-state for the registered path: capture on in_valid, otherwise hold.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        c_d         = c_q;
        parity_d    = parity_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            c_d         = x;
            parity_d    = ^x;
            out_valid_d = 1'b1;
        end
    end

    // Registered path state; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops sampling the pre-edge values.
            c_q         <= c_d;
            parity_q    <= parity_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign parity    = parity_q;
    assign out_valid = out_valid_q;

`ifdef EXOR_GATE_DIFF_COUNT_EN
    // Popcount width covers 0..WIDTH; the sum has one spare bit so the
    // saturation test sees the true total before clamping.
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] diff_cnt_d;
    logic [CNT_W-1:0] diff_cnt_q;
    logic [SUM_W-1:0] sum;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Saturating accumulate of differing bits for each accepted sample.
    always_comb begin
        diff_cnt_d = diff_cnt_q;
        sum        = SUM_W'(diff_cnt_q) + SUM_W'(popcount(x));
        if (in_valid) begin
            diff_cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_cnt_q <= '0;
        end else begin
            diff_cnt_q <= diff_cnt_d;
        end
    end

    assign diff_cnt = diff_cnt_q;
`else
    assign diff_cnt = '0;
`endif

endmodule

// File: tb/tb_exor_gate.sv
// Self-checking bench for exor_gate: a WIDTH=1 instance and a WIDTH=8,
// CNT_W=4 instance checked against a behavioural model.
module tb_exor_gate;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, v1;
    logic       c1, cq1, ov1, p1;
    logic [15:0] dc1;

    logic [7:0] a8, b8;
    logic       v8;
    logic [7:0] c8, cq8;
    logic       ov8, p8;
    logic [3:0] dc8;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic       m_cq1, m_p1, m_ov1;
    int         m_cnt1;
    logic [7:0] m_cq8;
    logic       m_p8, m_ov8;
    int         m_cnt8;

    exor_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .in_valid(v1),
        .c_q(cq1), .out_valid(ov1), .parity(p1), .diff_cnt(dc1)
    );

    exor_gate #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .in_valid(v8),
        .c_q(cq8), .out_valid(ov8), .parity(p8), .diff_cnt(dc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    function automatic int exp_cnt(input int m);
`ifdef EXOR_GATE_DIFF_COUNT_EN
        return m;
`else
        return 0 * m;
`endif
    endfunction

    task automatic model_reset();
        m_cq1 = 1'b0; m_p1 = 1'b0; m_ov1 = 1'b0; m_cnt1 = 0;
        m_cq8 = 8'h00; m_p8 = 1'b0; m_ov8 = 1'b0; m_cnt8 = 0;
    endtask

    // Advance the model with the current inputs, then cross one rising edge.
    task automatic tick();
        if (rst_n) begin
            if (v1) begin
                m_cq1  = a1 ^ b1;
                m_p1   = ($countones(a1 ^ b1) % 2) == 1;
                m_cnt1 = sat(m_cnt1 + $countones(a1 ^ b1), 65535);
            end
            m_ov1 = v1;
            if (v8) begin
                m_cq8  = a8 ^ b8;
                m_p8   = ($countones(a8 ^ b8) % 2) == 1;
                m_cnt8 = sat(m_cnt8 + $countones(a8 ^ b8), 15);
            end
            m_ov8 = v8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag);
        check({tag, "/w1.c"},         32'(c1),  32'(a1 ^ b1));
        check({tag, "/w1.c_q"},       32'(cq1), 32'(m_cq1));
        check({tag, "/w1.parity"},    32'(p1),  32'(m_p1));
        check({tag, "/w1.out_valid"}, 32'(ov1), 32'(m_ov1));
        check({tag, "/w1.diff_cnt"},  32'(dc1), 32'(exp_cnt(m_cnt1)));
    endtask

    task automatic check8(input string tag);
        check({tag, "/w8.c"},         32'(c8),  32'(a8 ^ b8));
        check({tag, "/w8.c_q"},       32'(cq8), 32'(m_cq8));
        check({tag, "/w8.parity"},    32'(p8),  32'(m_p8));
        check({tag, "/w8.out_valid"}, 32'(ov8), 32'(m_ov8));
        check({tag, "/w8.diff_cnt"},  32'(dc8), 32'(exp_cnt(m_cnt8)));
    endtask

    initial begin
        logic [1:0] ab;

        // Reset state; c must already be valid during reset.
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b0;
        a8 = 8'hA5; b8 = 8'h0F; v8 = 1'b0;
        model_reset();
        #2;
        check1("reset");
        check8("reset");
        check("reset/c_during_reset", 32'(c8), 32'h0000_00AA);
        rst_n = 1'b1;
        tick();
        check1("release");
        check8("release");

        // Plain XOR truth table on the 1-bit gate.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1];
            b1 = ab[0];
            #1;
            check($sformatf("truth_%0d%0d", a1, b1), 32'(c1), 32'((i == 1 || i == 2) ? 1 : 0));
            #9;
        end
        @(posedge clk);
        #1;

        // 1-bit capture then hold.
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        tick();
        check1("w1_capture");
        check("w1_capture/c_q_is_1", 32'(cq1), 32'h1);
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
        tick();
        check1("w1_hold");
        check("w1_hold/out_valid_0", 32'(ov1), 32'h0);

        // 8-bit captures.
        a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
        #1;
        check("w8_comb/c_CC", 32'(c8), 32'h0000_00CC);
        tick();
        check8("w8_F0_3C");
        check("w8_F0_3C/c_q_CC", 32'(cq8), 32'h0000_00CC);
        a8 = 8'h01; b8 = 8'h00;
        tick();
        check8("w8_01_00");
        check("w8_01_00/parity_1", 32'(p8), 32'h1);

        // Asynchronous reset in mid-stream.
        a8 = 8'hF0; b8 = 8'h3C;
        tick();
        check8("pre_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        a8 = 8'h12; b8 = 8'h34;
        #1;
        check8("async_reset");
        tick();
        check8("edge_in_reset");
        #2;
        rst_n = 1'b1;
        tick();
        check8("resume");

        // Randomized traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); v1 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom); b8 = 8'($urandom); v8 = 1'($urandom_range(0, 1));
            tick();
            check1($sformatf("rand%0d", i));
            check8($sformatf("rand%0d", i));
        end

        // Counter saturation: three samples with every bit differing.
        v1 = 1'b0; v8 = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        v8 = 1'b1;
        a8 = 8'hFF; b8 = 8'h00;
        tick();
        check8("sat1");
        check("sat1/diff_cnt", 32'(dc8), 32'(exp_cnt(8)));
        a8 = 8'h0F; b8 = 8'hF0;
        tick();
        check8("sat2");
        check("sat2/diff_cnt", 32'(dc8), 32'(exp_cnt(15)));
        a8 = 8'hAA; b8 = 8'h55;
        tick();
        check8("sat3");
        check("sat3/diff_cnt", 32'(dc8), 32'(exp_cnt(15)));
        v8 = 1'b0;
        tick();
        check8("sat_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
